// File: rtl/ram_master_pkg.sv
// ram_master_pkg
//   Shared definitions for the RAM burst master: FSM state encoding and the
//   default address, data and burst-length widths.
package ram_master_pkg;

  localparam int AW_DEF = 8;  // address width, matches RAM addr
  localparam int DW_DEF = 8;  // data width, matches RAM data_in/data_out
  localparam int LW_DEF = 8;  // burst-length field width (beats minus one)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage : ram_master_pkg

// File: rtl/ram_rd_skid_fifo.sv
// ram_rd_skid_fifo
//   Two-entry buffer for read beats returning from the RAM.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset (flushes the buffer)
//     push_i     write data_i this cycle (ignored when full and not popping)
//     data_i     beat to store
//     pop_i      consumer takes the head this cycle (ignored when empty)
//     valid_o    buffer not empty
//     data_o     head entry
//     count_o    current occupancy, 0..2; the producer uses it as its credit
module ram_rd_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop_i & (count_q != 2'd0);
  // A push into a full buffer is fine when the head leaves in the same cycle.
  assign do_push = push_i & ((count_q != 2'd2) | do_pop);

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    localparam logic IDX = 1'(gi);
    logic [W-1:0] entry_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        entry_q <= '0;
      end else if (do_push && (wr_ptr_q == IDX)) begin
        entry_q <= data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = rd_ptr_q ? g_entry[1].entry_q : g_entry[0].entry_q;
  assign count_o = count_q;

endmodule : ram_rd_skid_fifo

// File: rtl/ram_burst_master.sv
// ram_burst_master
//   Initiator for a single-port RAM (WE/RE/addr/data_in -> data_out/valid_out).
//   Takes burst commands on a valid/ready port, pulls write beats from a
//   valid/ready stream, and returns read beats on a valid/ready stream with
//   backpressure through a two-entry skid buffer.
//   Ports:
//     clk, rst                           clock, asynchronous active-high reset
//     cmd_valid/ready, cmd_write,        burst command (cmd_len = beats - 1)
//       cmd_addr, cmd_len
//     wr_valid/ready, wr_data            write beat stream
//     rd_valid/ready, rd_data, rd_last   read beat stream, rd_last on final beat
//     mem_we, mem_re, mem_addr,          RAM request side
//       mem_wdata
//     mem_rdata, mem_rvalid              RAM return (one cycle after mem_re)
//     busy                               FSM not idle
//     done                               one-cycle pulse after a burst completes
module ram_burst_master
  import ram_master_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q;      // next RAM address to write/issue
  logic [LW-1:0] len_q;       // beats minus one of the current burst
  logic [LW-1:0] beat_q;      // beats written / reads issued so far
  logic [LW-1:0] pop_cnt_q;   // read beats handed to the consumer so far
  logic          outstanding_q;
  logic          done_q;

  logic          cmd_fire;
  logic          rd_pop;
  logic          rd_push;
  logic          read_room;
  logic          beat_last;
  logic [1:0]    fifo_count;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign rd_pop    = rd_valid & rd_ready;
  // Returns only count while a read is in flight; stray valids are dropped.
  assign rd_push   = mem_rvalid & outstanding_q;
  assign beat_last = (beat_q == len_q);
  // Room check counts the beat leaving the buffer this cycle as already free,
  // which keeps one beat per cycle flowing while the consumer keeps up and
  // still guarantees the buffer cannot overflow.
  assign read_room = ({1'b0, fifo_count} + {2'b00, outstanding_q}) <
                     (3'd2 + {2'b00, rd_pop});

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cmd_fire) state_d = cmd_write ? WRITE : READ;
      WRITE: if (mem_we && beat_last) state_d = IDLE;
      READ:  if (mem_re && beat_last) state_d = DRAIN;
      // The last beat leaving means every read has returned and drained.
      DRAIN: if (rd_pop && rd_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE:  cmd_ready = ~rst;  // held low while reset is asserted
      WRITE: begin
        wr_ready  = 1'b1;
        mem_we    = wr_valid;
        mem_wdata = wr_data;
      end
      READ:  mem_re = read_room;
      default: ;
    endcase
  end

  assign mem_addr = addr_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rd_last  = rd_valid & (pop_cnt_q == len_q);

  // ---------------- Burst datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      pop_cnt_q     <= '0;
      outstanding_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr_q    <= cmd_addr;
        len_q     <= cmd_len;
        beat_q    <= '0;
        pop_cnt_q <= '0;
      end else begin
        if (mem_we || mem_re) begin
          addr_q <= addr_q + 1'b1;  // wraps modulo 2^AW
          beat_q <= beat_q + 1'b1;
        end
        if (rd_pop) pop_cnt_q <= pop_cnt_q + 1'b1;
      end
      outstanding_q <= mem_re | (outstanding_q & ~mem_rvalid);
      done_q        <= (state_q != IDLE) && (state_d == IDLE);
    end
  end

  ram_rd_skid_fifo #(
    .W(DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rd_push),
    .data_i  (mem_rdata),
    .pop_i   (rd_ready),
    .valid_o (rd_valid),
    .data_o  (rd_data),
    .count_o (fifo_count)
  );

endmodule : ram_burst_master

// File: tb/tb_ram_burst_master.sv
module tb_ram_burst_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready, rd_last;
  logic [7:0] rd_data;
  logic       mem_we, mem_re, mem_rvalid;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       busy, done;

  always #5 clk = ~clk;

  ram_burst_master #(.AW(8), .DW(8), .LW(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .busy(busy), .done(done)
  );

  // Single-port RAM: registered read, valid one cycle after RE, no reset.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rvalid <= mem_re;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Reference model: expected RAM contents and expected beat sequences.
  logic [7:0]  model_mem [256];
  logic [15:0] exp_wr [$];   // {addr, data}
  logic [8:0]  exp_rd [$];   // {last, data}
  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt = 0, pop_cnt = 0, done_cnt = 0;
  logic [7:0] last_addr = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    check({tag, "_wr_ready"},  32'(wr_ready), 0);
    check({tag, "_rd_valid"},  32'(rd_valid), 0);
    check({tag, "_rd_data"},   32'(rd_data), 0);
    check({tag, "_rd_last"},   32'(rd_last), 0);
    check({tag, "_mem_we"},    32'(mem_we), 0);
    check({tag, "_mem_re"},    32'(mem_re), 0);
    check({tag, "_mem_addr"},  32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_done"},      32'(done), 0);
  endtask

  // Monitor: samples mid-cycle, compares every RAM write and every consumed
  // read beat against the expected queues.
  initial begin
    logic [15:0] ew;
    logic [8:0]  er;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_we || mem_re) check("we_re_exclusive", 32'(mem_we & mem_re), 0);
        if (mem_re) last_addr = mem_addr;
        if (mem_we) begin
          we_cnt++;
          last_addr = mem_addr;
          check("we_needs_wr_valid", 32'(wr_valid), 1);
          if (exp_wr.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_write: got addr=%02h data=%02h, expected no write", mem_addr, mem_wdata);
          end else begin
            ew = exp_wr.pop_front();
            check("write_addr", 32'(mem_addr), 32'(ew[15:8]));
            check("write_data", 32'(mem_wdata), 32'(ew[7:0]));
          end
        end
        if (rd_valid && rd_ready) begin
          pop_cnt++;
          if (exp_rd.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_read_beat: got data=%02h, expected no beat", rd_data);
          end else begin
            er = exp_rd.pop_front();
            check("read_data", 32'(rd_data), 32'(er[7:0]));
            check("read_last", 32'(rd_last), 32'(er[8]));
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic send_cmd(input bit wr, input logic [7:0] a, input logic [7:0] l);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    #1;
    while (!cmd_ready && n < 100) begin tick(); #1; n++; end
    check("cmd_handshake", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0; cmd_write = 1'b0;
  endtask

  // mode: 0 = stream always valid/ready, 1 = alternate cycles, 2 = random
  task automatic run_burst(input string tag, input bit wr, input logic [7:0] a,
                           input logic [7:0] l, input logic [7:0] base, input int mode,
                           input int exp_lat, input int exp_beats, input logic [7:0] exp_last);
    int we0, pop0, dn0, cyc, first, i;
    bit fire;
    logic [7:0] idx, d;
    we0 = we_cnt; pop0 = pop_cnt; dn0 = done_cnt;
    $display("[TB] %s %s addr=%02h len=%0d", tag, wr ? "WR" : "RD", a, l);
    for (int k = 0; k <= int'(l); k++) begin
      idx = a + 8'(k);
      if (wr) begin
        d = base + 8'(k);
        exp_wr.push_back({idx, d});
        model_mem[idx] = d;
      end else begin
        exp_rd.push_back({(k == int'(l)), model_mem[idx]});
      end
    end
    send_cmd(wr, a, l);
    if (wr) begin
      i = 0; cyc = 0;
      while (i <= int'(l) && cyc < 3000) begin
        case (mode)
          0: wr_valid = 1'b1;
          1: wr_valid = (cyc % 2 == 0);
          default: wr_valid = ($urandom_range(0, 2) != 0);
        endcase
        wr_data = base + 8'(i);
        #1;
        fire = wr_valid && wr_ready;
        tick();
        if (fire) i++;
        cyc++;
      end
      wr_valid = 1'b0; wr_data = 8'h00;
      check({tag, "_wr_accepted"}, i, int'(l) + 1);
      check({tag, "_beats"}, we_cnt - we0, exp_beats);
    end else begin
      cyc = 1; first = -1;
      while (exp_rd.size() != 0 && cyc < 3000) begin
        case (mode)
          0: rd_ready = 1'b1;
          1: rd_ready = (cyc % 2 == 1);
          default: rd_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (rd_valid && first < 0) first = cyc;
        tick();
        cyc++;
      end
      rd_ready = 1'b0;
      check({tag, "_rd_drained"}, exp_rd.size(), 0);
      check({tag, "_first_beat_cycle"}, first, exp_lat);
      check({tag, "_beats"}, pop_cnt - pop0, exp_beats);
    end
    check({tag, "_last_addr"}, 32'(last_addr), 32'(exp_last));
    #1;
    check({tag, "_done_pulse"}, 32'(done), 1);
    check({tag, "_cmd_ready_after"}, 32'(cmd_ready), 1);
    check({tag, "_busy_after"}, 32'(busy), 0);
    check({tag, "_no_extra_rd"}, 32'(rd_valid), 0);
    tick();
    #1;
    check({tag, "_done_single"}, done_cnt - dn0, 1);
    check({tag, "_wr_q_empty"}, exp_wr.size(), 0);
    tick();
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] len;
    logic [7:0] base;
    int         mode;
    int         exp_lat;
    int         exp_beats;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n, p0, rv;
    bit w;
    logic [7:0] a, l, b;

    vecs[0] = '{1'b1, 8'h00, 8'hFF, 8'h00, 0, 0, 256, 8'hFF}; // fill, longest burst
    vecs[1] = '{1'b1, 8'h10, 8'h03, 8'hA0, 0, 0, 4,   8'h13}; // A0..A3 at 10..13
    vecs[2] = '{1'b0, 8'h10, 8'h03, 8'h00, 0, 3, 4,   8'h13}; // readback, latency 3
    vecs[3] = '{1'b1, 8'hFE, 8'h03, 8'hC0, 0, 0, 4,   8'h01}; // address wrap
    vecs[4] = '{1'b0, 8'hFE, 8'h03, 8'h00, 0, 3, 4,   8'h01}; // wrapped readback
    vecs[5] = '{1'b0, 8'h40, 8'h07, 8'h00, 1, 3, 8,   8'h47}; // rd_ready toggling
    vecs[6] = '{1'b1, 8'h80, 8'h03, 8'h55, 1, 0, 4,   8'h83}; // wr_valid gaps
    vecs[7] = '{1'b0, 8'h80, 8'h00, 8'h00, 0, 3, 1,   8'h80}; // single beat

    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    rst = 1'b0;
    #1;
    check("cmd_ready_first_cycle", 32'(cmd_ready), 1);
    check("busy_after_reset", 32'(busy), 0);
    tick();

    for (int v = 0; v < 8; v++) begin
      run_burst($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].len,
                vecs[v].base, vecs[v].mode, vecs[v].exp_lat, vecs[v].exp_beats,
                vecs[v].exp_last);
    end

    // Reset in the middle of a read burst.
    $display("[TB] rst_mid RD addr=10 len=7, reset after 2 beats");
    for (int k = 0; k < 8; k++) exp_rd.push_back({(k == 7), model_mem[8'h10 + 8'(k)]});
    p0 = pop_cnt;
    send_cmd(1'b0, 8'h10, 8'd7);
    rd_ready = 1'b1;
    n = 0;
    while (pop_cnt - p0 < 2 && n < 50) begin tick(); n++; end
    check("rst_mid_two_beats", pop_cnt - p0, 2);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    exp_rd.delete();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_cmd_ready_release", 32'(cmd_ready), 1);
    rv = 0;
    repeat (5) begin tick(); #1; if (rd_valid) rv++; end
    check("rst_mid_no_rd_valid", rv, 0);
    tick();
    rd_ready = 1'b0;
    run_burst("rst_readback", 1'b0, 8'h10, 8'd7, 8'h00, 0, 3, 8, 8'h17);

    // Random traffic against the model.
    for (int t = 0; t < 30; t++) begin
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      l = 8'($urandom_range(0, 15));
      b = 8'($urandom);
      run_burst($sformatf("rnd%0d", t), w, a, l, b, 2, 3, int'(l) + 1, a + l);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ram_burst_master
